frame_pixel_streamer: RTL and testbench

//  Raster-scan source for the sliding-window datapath. On a start pulse, reads one
//  ROW_WIDTH x NUM_ROWS 8-bit frame from a synchronous frame-buffer RAM with 1-cycle

---
 rtl/frame_pixel_streamer_if.sv | 26 ++
 rtl/frame_pixel_streamer.sv | 106 ++++++++++
 tb/tb_frame_pixel_streamer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/frame_pixel_streamer_if.sv
// Stream, frame-buffer and control signals of the raster-scan pixel source.
interface frame_pixel_streamer_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_rdata;
    logic [7:0]            pixel_out;
    logic                  pixel_valid;
    logic                  pixel_ready;
    logic                  sof;
    logic                  eol;
    logic                  eof;

    modport master (
        input  start, mem_rdata, pixel_ready,
        output busy, done, mem_rd_en, mem_addr, pixel_out, pixel_valid, sof, eol, eof
    );
    modport slave (
        output start, mem_rdata, pixel_ready,
        input  busy, done, mem_rd_en, mem_addr, pixel_out, pixel_valid, sof, eol, eof
    );
endinterface

// File: rtl/frame_pixel_streamer.sv
// Reads one frame from a 1-cycle-latency RAM and streams it row-major on a
// valid/ready port with sof/eol/eof markers, through a credit-controlled 2-entry FIFO.
module frame_pixel_streamer #(
    parameter int ROW_WIDTH  = 100,
    parameter int NUM_ROWS   = 100,
    parameter int ADDR_WIDTH = $clog2(ROW_WIDTH*NUM_ROWS)
) (
    input  logic                  clk,
    input  logic                  reset,
    frame_pixel_streamer_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int CW = $clog2(ROW_WIDTH);
    localparam int RW = $clog2(NUM_ROWS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROW_WIDTH*NUM_ROWS-1);
    localparam logic [CW-1:0]         LAST_COL  = CW'(ROW_WIDTH-1);
    localparam logic [RW-1:0]         LAST_ROW  = RW'(NUM_ROWS-1);

    logic [1:0]            state;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [ADDR_WIDTH-1:0] addr_cnt, addr_last;
    logic                  inflight;
    logic                  tag_sof, tag_eol, tag_eof;
    logic [10:0]           ent0, ent1, head;
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            count;
    logic                  pop, rd_en, drained;

    assign head    = rd_ptr ? ent1 : ent0;
    assign pop     = (count != 2'd0) && bus.pixel_ready;
    // Issue only if the returning word is guaranteed a FIFO slot next cycle.
    assign rd_en   = (state == S_RUN) &&
                     (({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
    // FIFO becomes empty at this edge and nothing is still returning.
    assign drained = !inflight && ((count == 2'd0) || (count == 2'd1 && pop));

    assign bus.mem_rd_en   = rd_en;
    assign bus.mem_addr    = rd_en ? addr_cnt : addr_last;
    assign bus.busy        = (state != S_IDLE);
    assign bus.done        = (state == S_DONE);
    assign bus.pixel_valid = (count != 2'd0);
    assign bus.pixel_out   = head[7:0];
    assign bus.sof         = bus.pixel_valid & head[8];
    assign bus.eol         = bus.pixel_valid & head[9];
    assign bus.eof         = bus.pixel_valid & head[10];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            col       <= '0;
            row       <= '0;
            addr_cnt  <= '0;
            addr_last <= '0;
            inflight  <= 1'b0;
            tag_sof   <= 1'b0;
            tag_eol   <= 1'b0;
            tag_eof   <= 1'b0;
            ent0      <= '0;
            ent1      <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    state    <= S_RUN;
                    col      <= '0;
                    row      <= '0;
                    addr_cnt <= '0;
                end
                S_RUN:   if (rd_en && addr_cnt == LAST_ADDR) state <= S_DRAIN;
                S_DRAIN: if (drained) state <= S_DONE;
                default: state <= S_IDLE;
            endcase

            if (rd_en) begin
                addr_last <= addr_cnt;
                addr_cnt  <= addr_cnt + 1'b1;
                tag_sof   <= (row == '0) && (col == '0);
                tag_eol   <= (col == LAST_COL);
                tag_eof   <= (col == LAST_COL) && (row == LAST_ROW);
                if (col == LAST_COL) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            inflight <= rd_en;

            // Tags ride alongside the read so they meet the data one cycle later.
            if (inflight) begin
                if (wr_ptr) ent1 <= {tag_eof, tag_eol, tag_sof, bus.mem_rdata};
                else        ent0 <= {tag_eof, tag_eol, tag_sof, bus.mem_rdata};
                wr_ptr <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Randomised frames and consumer backpressure checked against a frame-order reference.
module tb_frame_pixel_streamer;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W*H;
    localparam int AW = $clog2(N);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    frame_pixel_streamer_if #(.ADDR_WIDTH(AW)) bus();

    frame_pixel_streamer #(.ROW_WIDTH(W), .NUM_ROWS(H), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] ram [N];
    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= ram[int'(bus.mem_addr) % N];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int npass = 0, ntot = 0;
    task automatic chk(input string tag, input int obs, input int exp);
        ntot++;
        if (obs == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // consumer ready pattern
    int rmode = 0;
    int t_start = 0;
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       bus.pixel_ready = 1'b1;
            1:       bus.pixel_ready = ~bus.pixel_ready;
            2:       bus.pixel_ready = 1'($urandom_range(0, 1));
            default: bus.pixel_ready = (cyc > t_start + 10);
        endcase
    end

    // monitor: reference is simply ram[] in index order with tags derived from the index
    int xi, n_rd, n_done, t_first_rd, t_first_x, t_last_x, t_done;
    logic       hold_v = 1'b0;
    logic [7:0] hold_px;
    always @(negedge clk) begin
        if (reset) hold_v = 1'b0;
        else begin
            if (bus.mem_rd_en) begin
                if (n_rd == 0) t_first_rd = cyc;
                chk("addr", int'(bus.mem_addr), n_rd);
                n_rd++;
            end
            if (hold_v) chk("head_hold", {bus.pixel_valid, bus.pixel_out}, {1'b1, hold_px});
            if (bus.pixel_valid && bus.pixel_ready) begin
                if (xi < N) begin
                    if (xi == 0) t_first_x = cyc;
                    chk("pixel", bus.pixel_out, ram[xi]);
                    chk("sof", bus.sof, xi == 0);
                    chk("eol", bus.eol, (xi % W) == W-1);
                    chk("eof", bus.eof, xi == N-1);
                end else chk("extra_pixel", xi, N-1);
                t_last_x = cyc;
                xi++;
            end
            chk("credit", (n_rd - xi) <= 2, 1);
            hold_v  = bus.pixel_valid && !bus.pixel_ready;
            hold_px = bus.pixel_out;
            if (bus.done) begin
                n_done++;
                t_done = cyc;
                chk("done_after_last", xi, N);
            end
        end
    end

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"},  bus.busy, 0);
        chk({tag, "_done"},  bus.done, 0);
        chk({tag, "_valid"}, bus.pixel_valid, 0);
        chk({tag, "_rd_en"}, bus.mem_rd_en, 0);
        chk({tag, "_pixel"}, bus.pixel_out, 0);
        chk({tag, "_tags"},  {bus.sof, bus.eol, bus.eof}, 0);
    endtask

    task automatic begin_frame(input int mode, input bit fresh);
        if (fresh) foreach (ram[i]) ram[i] = 8'($urandom);
        xi = 0; n_rd = 0; n_done = 0;
        rmode = mode;
        t_start = cyc + 1;
        @(posedge clk); #1;
        bus.start = 1'b1;
        chk("busy_at_start", bus.busy, 0);
    endtask

    task automatic run_frame(input int mode, input bit fresh, input int extra);
        int k;
        begin_frame(mode, fresh);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
            bus.start = (extra != 0) && (cyc == t_start + extra);
            chk("busy", bus.busy, 1);
            if (mode == 3 && cyc == t_start + 10) begin
                chk("stall_reads", n_rd, 2);
                chk("stall_valid", bus.pixel_valid, 1);
                chk("stall_head", bus.pixel_out, ram[0]);
            end
        end while (!bus.done && k < 400);
        if (!bus.done) chk("timeout", 0, 1);
        @(negedge clk); #1;
        chk("xfers", xi, N);
        chk("done_pulses", n_done, 1);
        if (mode == 0) begin
            chk("lat_first_rd", t_first_rd - t_start, 1);
            chk("lat_first_px", t_first_x - t_start, 3);
            chk("lat_last_px", t_last_x - t_start, 2 + N);
            chk("lat_done", t_done - t_start, 3 + N);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.pixel_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_quiet("reset");

        foreach (ram[i]) ram[i] = 8'(i + 8'h10);
        run_frame(0, 1'b0, 0);     // reference timing, ready held high
        run_frame(1, 1'b1, 0);     // ready toggling
        run_frame(3, 1'b1, 0);     // ready low for 10 cycles after start
        run_frame(0, 1'b1, 5);     // start again while busy

        // abort mid-frame
        begin_frame(0, 1'b1);
        while (cyc < t_start + 7) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_quiet("abort");
        run_frame(0, 1'b0, 0);

        // back-to-back frames on the same contents, then random backpressure
        run_frame(2, 1'b1, 0);
        run_frame(2, 1'b0, 0);
        for (int f = 0; f < 3; f++) run_frame(2, 1'b1, 0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
